mcast_channel_router: RTL and testbench

//  Next-generation column multicaster: one per PE on a X/Y bus. Matches bus ID against a stored TAG,

---
 rtl/mcast_pkg.sv | 19 +
 rtl/mcast_sync_fifo.sv | 56 +++++
 rtl/mcast_channel_router.sv | 226 ++++++++++++++++++++++
 tb/tb_mcast_channel_router.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mcast_pkg.sv
// Shared types and helpers for the column multicast router.
package mcast_pkg;

    typedef enum logic {
        T_IDLE,
        T_DRAIN
    } tag_state_e;

    typedef enum logic {
        K_IDLE,
        K_LOAD
    } kern_state_e;

    // All-ones ID of the given width addresses every router on the bus.
    function automatic logic [31:0] bcast_id(input int unsigned id_w);
        return (32'd1 << id_w) - 32'd1;
    endfunction

endpackage

// File: rtl/mcast_sync_fifo.sv
// Single-clock FIFO with occupancy count; push while full is honoured only alongside a pop.
module mcast_sync_fifo
    import mcast_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; reset discards any buffered words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mcast_channel_router.sv
// Column multicaster: tag-matched inbound FIFOs toward the PE, skid-buffered psum return to the bus.
module mcast_channel_router
    import mcast_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int ID_W      = $clog2(NUM_COL) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_W-1:0]         bus_id,
    input  logic [ID_W-1:0]         cfg_tag,
    input  logic                    flush_tag,
    output logic                    tag_busy,
    input  logic [7:0]              kernel_size,
    input  logic                    flush_kernel,
    output logic                    kernel_busy,
    input  logic [DATA_WIDTH-1:0]   ifmap_b_data,
    input  logic                    ifmap_b_valid,
    output logic                    ifmap_b_ready,
    input  logic [DATA_WIDTH-1:0]   fltr_b_data,
    input  logic                    fltr_b_valid,
    output logic                    fltr_b_ready,
    input  logic [2*DATA_WIDTH-1:0] psum_b_data,
    input  logic                    psum_b_valid,
    output logic                    psum_b_ready,
    output logic [DATA_WIDTH-1:0]   ifmap_p_data,
    output logic                    ifmap_p_valid,
    input  logic                    ifmap_p_ready,
    output logic [DATA_WIDTH-1:0]   fltr_p_data,
    output logic                    fltr_p_valid,
    input  logic                    fltr_p_ready,
    output logic [2*DATA_WIDTH-1:0] psum_p_data,
    output logic                    psum_p_valid,
    input  logic                    psum_p_ready,
    input  logic [2*DATA_WIDTH-1:0] psum_r_data,
    input  logic                    psum_r_valid,
    output logic                    psum_r_ready,
    output logic [2*DATA_WIDTH-1:0] psum_o_data,
    output logic                    psum_o_valid,
    input  logic                    psum_o_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ID_W-1:0] BCAST_ID = ID_W'(bcast_id(ID_W));

    tag_state_e  tag_state, tag_state_next;
    kern_state_e kern_state, kern_state_next;

    logic [ID_W-1:0] tag, tag_next;
    logic [ID_W-1:0] tag_latch, tag_latch_next;
    logic [7:0]      kcnt, kcnt_next;
    logic [7:0]      ksize, ksize_next;

    logic hit;
    logic fltr_hit;
    logic draining;
    logic inbound_empty;

    logic ifmap_full, ifmap_empty;
    logic fltr_full, fltr_empty;
    logic psum_full, psum_empty;
    logic [CW-1:0] ifmap_count, fltr_count, psum_count;

    logic ifmap_push, fltr_push, psum_push;

    logic [2*DATA_WIDTH-1:0] skid_data;
    logic                    skid_valid;
    logic                    ret_fire;

    assign hit           = (bus_id == tag) | (bus_id == BCAST_ID);
    assign fltr_hit      = hit & kernel_busy;
    assign draining      = (tag_state == T_DRAIN);
    assign inbound_empty = (ifmap_count == '0) & (fltr_count == '0) & (psum_count == '0);

    // Misses are always accepted and dropped; hits back-pressure on a full FIFO.
    assign ifmap_b_ready = ~draining & (hit      ? ~ifmap_full : 1'b1);
    assign fltr_b_ready  = ~draining & (fltr_hit ? ~fltr_full  : 1'b1);
    assign psum_b_ready  = ~draining & (hit      ? ~psum_full  : 1'b1);

    assign ifmap_push = ifmap_b_valid & ifmap_b_ready & hit;
    assign fltr_push  = fltr_b_valid  & fltr_b_ready  & fltr_hit;
    assign psum_push  = psum_b_valid  & psum_b_ready  & hit;

    assign ifmap_p_valid = ~ifmap_empty;
    assign fltr_p_valid  = ~fltr_empty;
    assign psum_p_valid  = ~psum_empty;

    assign tag_busy    = draining;
    assign kernel_busy = (kern_state == K_LOAD);

    mcast_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_ifmap_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ifmap_push),
        .push_data (ifmap_b_data),
        .pop       (ifmap_p_ready),
        .pop_data  (ifmap_p_data),
        .full      (ifmap_full),
        .empty     (ifmap_empty),
        .count     (ifmap_count)
    );

    mcast_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fltr_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fltr_push),
        .push_data (fltr_b_data),
        .pop       (fltr_p_ready),
        .pop_data  (fltr_p_data),
        .full      (fltr_full),
        .empty     (fltr_empty),
        .count     (fltr_count)
    );

    mcast_sync_fifo #(.WIDTH(2 * DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_psum_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (psum_push),
        .push_data (psum_b_data),
        .pop       (psum_p_ready),
        .pop_data  (psum_p_data),
        .full      (psum_full),
        .empty     (psum_empty),
        .count     (psum_count)
    );

    // Tag FSM and kernel FSM state registers with their datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_state  <= T_IDLE;
            tag        <= '0;
            tag_latch  <= '0;
            kern_state <= K_IDLE;
            kcnt       <= '0;
            ksize      <= '0;
        end else begin
            tag_state  <= tag_state_next;
            tag        <= tag_next;
            tag_latch  <= tag_latch_next;
            kern_state <= kern_state_next;
            kcnt       <= kcnt_next;
            ksize      <= ksize_next;
        end
    end

    // Tag update waits for all inbound FIFOs to drain; a repeat flush replaces the pending value.
    always_comb begin
        tag_state_next = tag_state;
        tag_next       = tag;
        tag_latch_next = tag_latch;
        case (tag_state)
            T_IDLE: begin
                if (flush_tag) begin
                    tag_latch_next = cfg_tag;
                    tag_state_next = T_DRAIN;
                end
            end
            T_DRAIN: begin
                if (flush_tag) tag_latch_next = cfg_tag;
                if (inbound_empty) begin
                    tag_state_next = T_IDLE;
                    tag_next       = flush_tag ? cfg_tag : tag_latch;
                end
            end
            default: tag_state_next = T_IDLE;
        endcase
    end

    // Kernel-load window counts filter hit pushes up to the size captured at flush.
    always_comb begin
        kern_state_next = kern_state;
        kcnt_next       = kcnt;
        ksize_next      = ksize;
        case (kern_state)
            K_IDLE: begin
                if (flush_kernel && (kernel_size != '0)) begin
                    kern_state_next = K_LOAD;
                    kcnt_next       = '0;
                    ksize_next      = kernel_size;
                end
            end
            K_LOAD: begin
                if (flush_kernel && (kernel_size != '0)) begin
                    kcnt_next  = '0;
                    ksize_next = kernel_size;
                end else if (fltr_push) begin
                    if (kcnt == ksize - 8'd1) begin
                        kern_state_next = K_IDLE;
                        kcnt_next       = '0;
                    end else begin
                        kcnt_next = kcnt + 8'd1;
                    end
                end
            end
            default: kern_state_next = K_IDLE;
        endcase
    end

    assign psum_r_ready = ~skid_valid;
    assign ret_fire     = psum_r_valid & psum_r_ready;

    // Return-path skid: output stage refills from the skid slot first, else straight from the PE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psum_o_valid <= 1'b0;
            psum_o_data  <= '0;
            skid_valid   <= 1'b0;
            skid_data    <= '0;
        end else if (!psum_o_valid || psum_o_ready) begin
            if (skid_valid) begin
                psum_o_data  <= skid_data;
                psum_o_valid <= 1'b1;
                skid_valid   <= 1'b0;
            end else begin
                psum_o_valid <= ret_fire;
                if (ret_fire) psum_o_data <= psum_r_data;
            end
        end else if (ret_fire) begin
            skid_data  <= psum_r_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mcast_channel_router.sv
// Directed self-checking bench for mcast_channel_router.
module tb_mcast_channel_router;

    localparam int DW   = 16;
    localparam int ID_W = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [ID_W-1:0] bus_id, cfg_tag;
    logic            flush_tag, tag_busy;
    logic [7:0]      kernel_size;
    logic            flush_kernel, kernel_busy;
    logic [DW-1:0]   ifmap_b_data, fltr_b_data, ifmap_p_data, fltr_p_data;
    logic            ifmap_b_valid, ifmap_b_ready, fltr_b_valid, fltr_b_ready;
    logic            psum_b_valid, psum_b_ready;
    logic [2*DW-1:0] psum_b_data, psum_p_data, psum_r_data, psum_o_data;
    logic            ifmap_p_valid, ifmap_p_ready, fltr_p_valid, fltr_p_ready;
    logic            psum_p_valid, psum_p_ready, psum_r_valid, psum_r_ready;
    logic            psum_o_valid, psum_o_ready;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    mcast_channel_router #(.DATA_WIDTH(DW), .NUM_COL(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .bus_id(bus_id), .cfg_tag(cfg_tag), .flush_tag(flush_tag), .tag_busy(tag_busy),
        .kernel_size(kernel_size), .flush_kernel(flush_kernel), .kernel_busy(kernel_busy),
        .ifmap_b_data(ifmap_b_data), .ifmap_b_valid(ifmap_b_valid), .ifmap_b_ready(ifmap_b_ready),
        .fltr_b_data(fltr_b_data), .fltr_b_valid(fltr_b_valid), .fltr_b_ready(fltr_b_ready),
        .psum_b_data(psum_b_data), .psum_b_valid(psum_b_valid), .psum_b_ready(psum_b_ready),
        .ifmap_p_data(ifmap_p_data), .ifmap_p_valid(ifmap_p_valid), .ifmap_p_ready(ifmap_p_ready),
        .fltr_p_data(fltr_p_data), .fltr_p_valid(fltr_p_valid), .fltr_p_ready(fltr_p_ready),
        .psum_p_data(psum_p_data), .psum_p_valid(psum_p_valid), .psum_p_ready(psum_p_ready),
        .psum_r_data(psum_r_data), .psum_r_valid(psum_r_valid), .psum_r_ready(psum_r_ready),
        .psum_o_data(psum_o_data), .psum_o_valid(psum_o_valid), .psum_o_ready(psum_o_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus_id = '0; cfg_tag = '0; flush_tag = 1'b0;
        kernel_size = '0; flush_kernel = 1'b0;
        ifmap_b_data = '0; ifmap_b_valid = 1'b0; fltr_b_data = '0; fltr_b_valid = 1'b0;
        psum_b_data = '0; psum_b_valid = 1'b0;
        ifmap_p_ready = 1'b0; fltr_p_ready = 1'b0; psum_p_ready = 1'b0;
        psum_r_data = '0; psum_r_valid = 1'b0; psum_o_ready = 1'b0;
        #1;
        chk("rst_ifmap_p_valid", ifmap_p_valid, 0);
        chk("rst_psum_o_valid", psum_o_valid, 0);
        chk("rst_tag_busy", tag_busy, 0);
        chk("rst_kernel_busy", kernel_busy, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // 1: set tag=3 with empty FIFOs, busy for exactly one cycle
        flush_tag = 1'b1; cfg_tag = 4'd3;
        tick();
        flush_tag = 1'b0; #1;
        chk("t1_tag_busy_on", tag_busy, 1);
        tick();
        chk("t1_tag_busy_off", tag_busy, 0);
        bus_id = 4'd3; ifmap_b_data = 16'h0011; ifmap_b_valid = 1'b1; #1;
        chk("t1_ready_hit", ifmap_b_ready, 1);
        tick();
        chk("t1_latency_valid", ifmap_p_valid, 1);
        ifmap_b_data = 16'h0022;
        tick();
        bus_id = 4'd5; ifmap_b_data = 16'h0033; #1;
        chk("t1_ready_miss", ifmap_b_ready, 1);
        tick();
        ifmap_b_valid = 1'b0; ifmap_p_ready = 1'b1; #1;
        chk("t1_word0", ifmap_p_data, 16'h0011);
        tick();
        chk("t1_word1", ifmap_p_data, 16'h0022);
        tick();
        chk("t1_miss_dropped", ifmap_p_valid, 0);
        ifmap_p_ready = 1'b0;

        // 2: broadcast psum reaches the PE regardless of tag
        bus_id = 4'hF; psum_b_data = 32'hDEADBEEF; psum_b_valid = 1'b1; #1;
        chk("t2_ready", psum_b_ready, 1);
        tick();
        psum_b_valid = 1'b0; #1;
        chk("t2_valid", psum_p_valid, 1);
        chk("t2_data", psum_p_data, 32'hDEADBEEF);
        psum_p_ready = 1'b1;
        tick();
        chk("t2_empty", psum_p_valid, 0);
        psum_p_ready = 1'b0;

        // return path: skid absorbs one beat under back-pressure
        psum_r_data = 32'h1111_0001; psum_r_valid = 1'b1; #1;
        chk("ret_ready0", psum_r_ready, 1);
        tick();
        psum_r_data = 32'h2222_0002; #1;
        chk("ret_o_valid", psum_o_valid, 1);
        chk("ret_o_data0", psum_o_data, 32'h1111_0001);
        chk("ret_ready1", psum_r_ready, 1);
        tick();
        psum_r_valid = 1'b0; #1;
        chk("ret_skid_full", psum_r_ready, 0);
        chk("ret_hold", psum_o_data, 32'h1111_0001);
        psum_o_ready = 1'b1;
        tick();
        chk("ret_o_data1", psum_o_data, 32'h2222_0002);
        chk("ret_ready_back", psum_r_ready, 1);
        tick();
        chk("ret_empty", psum_o_valid, 0);

        // 3: fill ifmap FIFO, 5th beat refused, order preserved
        bus_id = 4'd3; ifmap_b_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ifmap_b_data = 16'h00A0 + 16'(i); #1;
            chk($sformatf("t3_ready%0d", i), ifmap_b_ready, (i < 4) ? 1 : 0);
            tick();
        end
        ifmap_b_valid = 1'b0; ifmap_p_ready = 1'b1; #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_data%0d", i), ifmap_p_data, 16'h00A0 + 16'(i));
            tick();
        end
        chk("t3_drained", ifmap_p_valid, 0);
        ifmap_p_ready = 1'b0;

        // 4: deferred tag update waits for drain
        ifmap_b_valid = 1'b1; ifmap_b_data = 16'h0055;
        tick();
        ifmap_b_data = 16'h0066;
        tick();
        ifmap_b_valid = 1'b0;
        flush_tag = 1'b1; cfg_tag = 4'd6;
        tick();
        flush_tag = 1'b0;
        bus_id = 4'd6; ifmap_b_data = 16'h0077; ifmap_b_valid = 1'b1; #1;
        chk("t4_busy", tag_busy, 1);
        chk("t4_ifmap_stall", ifmap_b_ready, 0);
        chk("t4_psum_stall", psum_b_ready, 0);
        tick();
        ifmap_p_ready = 1'b1; #1;
        chk("t4_q0", ifmap_p_data, 16'h0055);
        tick();
        chk("t4_q1", ifmap_p_data, 16'h0066);
        tick();
        chk("t4_busy_after_drain", tag_busy, 1);
        chk("t4_still_stalled", ifmap_b_ready, 0);
        tick();
        chk("t4_busy_clear", tag_busy, 0);
        chk("t4_new_tag_ready", ifmap_b_ready, 1);
        tick();
        ifmap_b_valid = 1'b0; #1;
        chk("t4_new_tag_valid", ifmap_p_valid, 1);
        chk("t4_new_tag_data", ifmap_p_data, 16'h0077);
        tick();
        ifmap_p_ready = 1'b0;

        // 5: kernel window of 3 filter words, size change mid-load ignored
        kernel_size = 8'd3; flush_kernel = 1'b1;
        tick();
        flush_kernel = 1'b0; kernel_size = 8'd7; #1;
        chk("t5_busy_on", kernel_busy, 1);
        fltr_p_ready = 1'b1; fltr_b_valid = 1'b1; bus_id = 4'd6;
        for (int i = 0; i < 5; i++) begin
            fltr_b_data = 16'h00F0 + 16'(i); #1;
            chk($sformatf("t5_ready%0d", i), fltr_b_ready, 1);
            tick();
            chk($sformatf("t5_pvalid%0d", i), fltr_p_valid, (i < 3) ? 1 : 0);
            if (i < 3) chk($sformatf("t5_pdata%0d", i), fltr_p_data, 16'h00F0 + 16'(i));
            chk($sformatf("t5_busy%0d", i), kernel_busy, (i < 2) ? 1 : 0);
        end
        fltr_b_valid = 1'b0; fltr_p_ready = 1'b0;

        // 6: async reset mid-operation
        ifmap_b_valid = 1'b1; ifmap_b_data = 16'h0081;
        tick();
        ifmap_b_data = 16'h0082;
        kernel_size = 8'd2; flush_kernel = 1'b1;
        tick();
        ifmap_b_valid = 1'b0; flush_kernel = 1'b0;
        psum_b_valid = 1'b1; psum_b_data = 32'h0000_CAFE;
        tick();
        psum_b_valid = 1'b0; #1;
        chk("t6_pre_kbusy", kernel_busy, 1);
        chk("t6_pre_ivalid", ifmap_p_valid, 1);
        chk("t6_pre_pvalid", psum_p_valid, 1);
        #2 rst = 1'b1; #1;
        chk("t6_ivalid", ifmap_p_valid, 0);
        chk("t6_pvalid", psum_p_valid, 0);
        chk("t6_kbusy", kernel_busy, 0);
        chk("t6_tbusy", tag_busy, 0);
        tick();
        rst = 1'b0;
        tick();
        bus_id = 4'd6; ifmap_b_valid = 1'b1; ifmap_b_data = 16'h0098;
        tick();
        ifmap_b_valid = 1'b0; #1;
        chk("t6_old_tag_miss", ifmap_p_valid, 0);
        bus_id = 4'd0; ifmap_b_valid = 1'b1; ifmap_b_data = 16'h0099;
        tick();
        ifmap_b_valid = 1'b0; #1;
        chk("t6_tag0_valid", ifmap_p_valid, 1);
        chk("t6_tag0_data", ifmap_p_data, 16'h0099);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
